// File: rtl/dme_reset_seq.sv
// Per-slot DME reset sequencer: power-good qualification, timed reset release, fault latching.
module dme_reset_seq #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned RLS_DLY = 16,
  parameter int unsigned PWR_TMO = 64
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     PWRGD_PS_PWROK_3V3,
  input  logic                     RST_PLTRST_N,
  input  logic [NUM_CH-1:0]        DME_PWRGD,
  input  logic [NUM_CH-1:0]        DME_Absent,
  input  logic [NUM_CH*ID_W-1:0]   DMEID,
  output logic [NUM_CH-1:0]        RST_DME_N,
  output logic [NUM_CH-1:0]        DMEReady,
  output logic [NUM_CH-1:0]        DMEFault
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PWR_TMO - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RLS_DLY - 1);
  localparam logic [ID_W-1:0]  ID_FLOAT = {ID_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PWR = 3'd1,
    DELAY    = 3'd2,
    RUN      = 3'd3,
    FAULT    = 3'd4
  } state_t;

  logic                   psok_m, psok_s;
  logic                   plt_m, plt_s;
  logic [NUM_CH-1:0]      pg_m, pg_s;
  logic [NUM_CH-1:0]      abs_m, abs_s;
  logic [NUM_CH*ID_W-1:0] id_m, id_s;
  logic                   go;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] rst_d, rdy_d, flt_d;

  // Two-flop synchronisers; absence straps reset to "absent" so slots stay quiet.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      psok_m <= 1'b0;
      psok_s <= 1'b0;
      plt_m  <= 1'b0;
      plt_s  <= 1'b0;
      pg_m   <= '0;
      pg_s   <= '0;
      abs_m  <= '1;
      abs_s  <= '1;
      id_m   <= '0;
      id_s   <= '0;
    end else begin
      psok_m <= PWRGD_PS_PWROK_3V3;
      psok_s <= psok_m;
      plt_m  <= RST_PLTRST_N;
      plt_s  <= plt_m;
      pg_m   <= DME_PWRGD;
      pg_s   <= pg_m;
      abs_m  <= DME_Absent;
      abs_s  <= abs_m;
      id_m   <= DMEID;
      id_s   <= id_m;
    end
  end

  assign go = psok_s & plt_s;

  // Slot state, counter and registered outputs.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      RST_DME_N <= '0;
      DMEReady  <= '0;
      DMEFault  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      RST_DME_N <= rst_d;
      DMEReady  <= rdy_d;
      DMEFault  <= flt_d;
    end
  end

  // Next-state, counter and output decode per slot; GO low overrides everything.
  always_comb begin
    rst_d = '0;
    rdy_d = '0;
    flt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!go) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            cnt_d[i] = '0;
            if (!abs_s[i]) state_d[i] = WAIT_PWR;
          end
          WAIT_PWR: begin
            if (abs_s[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (pg_s[i]) begin
              state_d[i] = DELAY;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == TMO_LAST) begin
              state_d[i] = FAULT;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          DELAY: begin
            if (abs_s[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (!pg_s[i]) begin
              state_d[i] = WAIT_PWR;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DLY_LAST) begin
              state_d[i] = (id_s[i*ID_W +: ID_W] == ID_FLOAT) ? FAULT : RUN;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          RUN: begin
            if (abs_s[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (!pg_s[i]) begin
              state_d[i] = FAULT;
            end
          end
          FAULT: begin
            state_d[i] = FAULT;
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      rst_d[i] = (state_d[i] == RUN);
      rdy_d[i] = (state_d[i] == RUN);
      flt_d[i] = (state_d[i] == FAULT);
    end
  end

endmodule

// File: tb/tb_dme_reset_seq.sv
// Directed self-checking bench for dme_reset_seq (defaults: 2 slots, RLS_DLY=16, PWR_TMO=64).
module tb_dme_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psok;
  logic       plt_n;
  logic [1:0] pg;
  logic [1:0] absent;
  logic [7:0] id;
  logic [1:0] rst_dme_n;
  logic [1:0] ready;
  logic [1:0] fault;

  int total = 0;
  int bad   = 0;

  dme_reset_seq dut (
    .Clk                (clk),
    .ResetN             (rst_n),
    .PWRGD_PS_PWROK_3V3 (psok),
    .RST_PLTRST_N       (plt_n),
    .DME_PWRGD          (pg),
    .DME_Absent         (absent),
    .DMEID              (id),
    .RST_DME_N          (rst_dme_n),
    .DMEReady           (ready),
    .DMEFault           (fault)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    psok   = 1'b0;
    plt_n  = 1'b0;
    pg     = 2'b00;
    absent = 2'b11;
    id     = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Enable GO with both slots present, then raise both power-goods (stops right after the raise).
  task automatic start_slots(input logic [7:0] ids);
    psok   = 1'b1;
    plt_n  = 1'b1;
    absent = 2'b00;
    id     = ids;
    tick(4);
    pg = 2'b11;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    psok   = 1'b1;
    plt_n  = 1'b1;
    pg     = 2'b11;
    absent = 2'b00;
    id     = 8'h33;
    tick(3);
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL reset_rst got=%b exp=00", rst_dme_n); end
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", ready); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL reset_fault got=%b exp=00", fault); end
    do_reset();
  endtask

  task automatic test_bringup();
    do_reset();
    start_slots(8'h33);
    tick(18);
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL bringup_early got=%b exp=00", rst_dme_n); end
    tick(1);
    total++; if (rst_dme_n !== 2'b11) begin bad++; $display("FAIL bringup_rst got=%b exp=11", rst_dme_n); end
    total++; if (ready !== 2'b11) begin bad++; $display("FAIL bringup_ready got=%b exp=11", ready); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL bringup_fault got=%b exp=00", fault); end
  endtask

  task automatic test_run_loss();
    do_reset();
    start_slots(8'h33);
    tick(19);
    pg = 2'b10;
    tick(2);
    total++; if (rst_dme_n !== 2'b11) begin bad++; $display("FAIL loss_before got=%b exp=11", rst_dme_n); end
    tick(1);
    total++; if (rst_dme_n !== 2'b10) begin bad++; $display("FAIL loss_rst got=%b exp=10", rst_dme_n); end
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL loss_fault got=%b exp=01", fault); end
    total++; if (ready !== 2'b10) begin bad++; $display("FAIL loss_ready got=%b exp=10", ready); end
    plt_n = 1'b0;
    tick(3);
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL plt_rst got=%b exp=00", rst_dme_n); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL plt_fault got=%b exp=00", fault); end
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL plt_ready got=%b exp=00", ready); end
  endtask

  task automatic test_timeout();
    do_reset();
    psok   = 1'b1;
    plt_n  = 1'b1;
    absent = 2'b10;
    id     = 8'h33;
    pg     = 2'b00;
    tick(66);
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL tmo_early got=%b exp=00", fault); end
    tick(1);
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL tmo_fault got=%b exp=01", fault); end
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL tmo_rst got=%b exp=00", rst_dme_n); end
    absent = 2'b11;
    tick(5);
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL tmo_sticky got=%b exp=01", fault); end
    plt_n = 1'b0;
    tick(2);
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL tmo_hold got=%b exp=01", fault); end
    tick(1);
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL tmo_clear got=%b exp=00", fault); end
    plt_n = 1'b1;
  endtask

  task automatic test_glitch();
    do_reset();
    start_slots(8'h33);
    tick(11);
    pg = 2'b01;
    tick(3);
    pg = 2'b11;
    tick(5);
    total++; if (rst_dme_n !== 2'b01) begin bad++; $display("FAIL glitch_slot0 got=%b exp=01", rst_dme_n); end
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL glitch_ready0 got=%b exp=01", ready); end
    tick(13);
    total++; if (rst_dme_n !== 2'b01) begin bad++; $display("FAIL glitch_early got=%b exp=01", rst_dme_n); end
    tick(1);
    total++; if (rst_dme_n !== 2'b11) begin bad++; $display("FAIL glitch_release got=%b exp=11", rst_dme_n); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL glitch_fault got=%b exp=00", fault); end
  endtask

  task automatic test_bad_id();
    do_reset();
    start_slots(8'hF3);
    tick(18);
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL badid_early got=%b exp=00", fault); end
    tick(1);
    total++; if (fault !== 2'b10) begin bad++; $display("FAIL badid_fault got=%b exp=10", fault); end
    total++; if (rst_dme_n !== 2'b01) begin bad++; $display("FAIL badid_rst got=%b exp=01", rst_dme_n); end
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL badid_ready got=%b exp=01", ready); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_slots(8'h33);
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({rst_dme_n, ready, fault} !== 6'b0) begin bad++; $display("FAIL async_delay got=%b exp=000000", {rst_dme_n, ready, fault}); end
    tick(1);
    rst_n = 1'b1;
    tick(19);
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL async_rel_early got=%b exp=00", rst_dme_n); end
    tick(1);
    total++; if (rst_dme_n !== 2'b11) begin bad++; $display("FAIL async_rel_run got=%b exp=11", rst_dme_n); end
    pg = 2'b00;
    tick(3);
    total++; if (fault !== 2'b11) begin bad++; $display("FAIL async_pre_fault got=%b exp=11", fault); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL async_fault got=%b exp=00", fault); end
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL async_fault_rst got=%b exp=00", rst_dme_n); end
    tick(1);
    rst_n = 1'b1;
    tick(4);
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL async_no_memory got=%b exp=00", fault); end
    pg = 2'b11;
    tick(18);
    total++; if (rst_dme_n !== 2'b00) begin bad++; $display("FAIL async_again_early got=%b exp=00", rst_dme_n); end
    tick(1);
    total++; if (rst_dme_n !== 2'b11) begin bad++; $display("FAIL async_again got=%b exp=11", rst_dme_n); end
  endtask

  initial begin
    rst_n  = 1'b0;
    psok   = 1'b0;
    plt_n  = 1'b0;
    pg     = 2'b00;
    absent = 2'b11;
    id     = 8'h00;
    tick(1);
    test_reset();
    test_bringup();
    test_run_loss();
    test_timeout();
    test_glitch();
    test_bad_id();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dme_reset_seq.md
DME_RESET_SEQ -- requirements
Module: dme_reset_seq

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent DME slots.
REQ-002 Parameter ID_W, default 4: width of each slot's ID field.
REQ-003 Parameter RLS_DLY, default 16: clock cycles DME_PWRGD must stay high before reset release; range 1..65535.
REQ-004 Parameter PWR_TMO, default 64: clock cycles allowed for DME_PWRGD to rise before a fault is declared; range 1..65535.
REQ-005 Clk  in  1  single block clock; all state changes occur on its rising edge.
REQ-006 ResetN  in  1  reset; asynchronous assertion, active-low.
REQ-007 PWRGD_PS_PWROK_3V3  in  1  PSU power-good, asynchronous.
REQ-008 RST_PLTRST_N  in  1  platform reset, active-low, asynchronous.
REQ-009 DME_PWRGD  in  NUM_CH  per-slot DME power-good, asynchronous.
REQ-010 DME_Absent  in  NUM_CH  per-slot presence; high means absent.
REQ-011 DMEID  in  NUM_CH*ID_W  per-slot ID straps; slot i occupies bits [i*ID_W +: ID_W].
REQ-012 RST_DME_N  out  NUM_CH  per-slot DME reset, active-low, registered.
REQ-013 DMEReady  out  NUM_CH  high when the slot is in state RUN, registered.
REQ-014 DMEFault  out  NUM_CH  high when the slot is in state FAULT, registered.

Function
REQ-015 Inputs in REQ-007 to REQ-011 shall each pass through a 2-flop synchroniser before use; all timing below counts from the synchroniser output (_s).
REQ-016 GO shall be PWRGD_PS_PWROK_3V3_s AND RST_PLTRST_N_s.
REQ-017 PRES[i] shall be NOT DME_Absent_s[i].
REQ-018 Each slot shall run an independent FSM with states IDLE, WAIT_PWR, DELAY, RUN and FAULT, and a 16-bit counter.
REQ-019 IDLE: go to WAIT_PWR when GO and PRES[i] are both high; clear the counter.
REQ-020 WAIT_PWR:
- GO or PRES low: go to IDLE.
- Else DME_PWRGD_s[i] high: go to DELAY and clear the counter.
- Else the counter reaching PWR_TMO-1: go to FAULT.
- Otherwise: increment the counter.
REQ-021 DELAY:
- GO or PRES low: go to IDLE.
- Else DME_PWRGD_s[i] low: go to WAIT_PWR and clear the counter (restart the qualification).
- Else counter = RLS_DLY-1 and ID is not all-ones: go to RUN.
- Else counter = RLS_DLY-1 and ID is all-ones (floating straps): go to FAULT.
- Otherwise: increment the counter.
REQ-022 RUN: GO or PRES low shall go to IDLE; otherwise DME_PWRGD_s[i] low shall go to FAULT.
REQ-023 FAULT shall be sticky; the only exit is GO low, which goes to IDLE. PRES loss alone shall not clear FAULT.
REQ-024 GO low shall take precedence over every other condition in every state.
REQ-025 Outputs shall be registered from the next state, so they change on the same edge as the state.
- RST_DME_N[i] = 1 only in RUN.
- DMEReady[i] = 1 only in RUN.
- DMEFault[i] = 1 only in FAULT.
REQ-026 A slot that is absent shall stay in IDLE with RST_DME_N = 0; other slots shall not be affected.
REQ-027 Reset release latency: RST_DME_N rises RLS_DLY+1 edges after DME_PWRGD_s first samples high, with GO and PRES held high.
REQ-028 Counter compare shall use the full 16-bit width; the counter shall never wrap.

Reset
REQ-029 While ResetN is low:
- All FSMs shall be in IDLE and all counters 0.
- RST_DME_N shall be all 0; DMEReady and DMEFault shall be all 0.
- Synchroniser flops shall be 0, except the DME_Absent synchronisers, which shall be 1.
REQ-030 ResetN asserted mid-operation shall force REQ-029 values asynchronously. After release, the FSM shall restart from IDLE with no memory of prior FAULT.

Verification
REQ-031 Nominal bring-up (NUM_CH=2, RLS_DLY=16):
- Stimulus: PSOK=1, PLTRST_N=1, both slots present, ID=4'h3, DME_PWRGD rises.
- Response: RST_DME_N=2'b11 and DMEReady=2'b11 exactly 17 edges after DME_PWRGD_s goes high.
REQ-032 Power-good timeout (PWR_TMO=64):
- Stimulus: slot 0 present, DME_PWRGD[0] held 0.
- Response: DMEFault[0]=1 64 edges after entering WAIT_PWR; RST_DME_N[0] stays 0.
- Response: PLTRST_N pulsed low returns the slot to IDLE with DMEFault[0]=0.
REQ-033 Glitch qualification:
- Stimulus: DME_PWRGD[1] drops for 3 cycles at DELAY count 10.
- Response: the slot returns to WAIT_PWR; release occurs 17 edges after the restored high; slot 0 is unaffected.
REQ-034 Invalid ID:
- Stimulus: DMEID slot 1 = 4'hF.
- Response: after RLS_DLY the slot goes to FAULT, RST_DME_N[1]=0, DMEFault[1]=1.
REQ-035 Run-time loss:
- Stimulus: in RUN, DME_PWRGD[0]=0.
- Response: RST_DME_N[0]=0 and DMEFault[0]=1 on the next state edge.
- Stimulus: in RUN, PLTRST_N=0 instead.
- Response: the slot goes to IDLE with DMEFault=0.
REQ-036 Asynchronous reset:
- Stimulus: ResetN pulsed low mid-DELAY and mid-FAULT.
- Response: all outputs are 0 immediately, without waiting for a clock edge; normal bring-up follows after release.
